// File: rtl/comm_crc_pkg.sv
// Shared CRC definitions for the DOM/DOMHub comm path: CRC-32 constants, engine
// states and the unrolled LFSR step used by both hardware and models.
package comm_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'h00000000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} crc_state_e;

  // Applies n serial LFSR steps to a w-bit remainder held in the low bits of rmder.
  function automatic logic [31:0] crc_step(
    input logic [31:0] rmder,
    input logic [15:0] bits,
    input int          n,
    input int          w         = 32,
    input logic [31:0] poly      = CRC32_POLY,
    input bit          msb_first = 1'b1
  );
    logic [31:0] r;
    logic [31:0] mask;
    logic [3:0]  idx;
    logic        fb;
    mask = 32'((33'h1 << w) - 33'h1);
    r    = rmder & mask;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        idx = msb_first ? 4'(n - 1 - i) : 4'(i);
        fb  = r[5'(w - 1)] ^ bits[idx];
        r   = ((r << 1) ^ (fb ? poly : 32'h0)) & mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational next-remainder logic: IN_W LFSR steps unrolled into one cycle.
module crc_lfsr_step
  import comm_crc_pkg::*;
#(
  parameter int          CRC_W     = 32,
  parameter int          IN_W      = 8,
  parameter logic [31:0] POLY      = CRC32_POLY,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [CRC_W-1:0] rmder,
  input  logic [IN_W-1:0]  bits,
  output logic [CRC_W-1:0] next_rmder
);

  logic [31:0] step_full;

  assign step_full  = crc_step(32'(rmder), 16'(bits), IN_W, CRC_W, POLY, MSB_FIRST);
  assign next_rmder = step_full[CRC_W-1:0];

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: IN_W bits per beat, packet framing FSM, registered result
// with a residue comparison for the receive side.
module crc_stream_engine
  import comm_crc_pkg::*;
#(
  parameter int               CRC_W     = 32,
  parameter logic [31:0]      POLY      = CRC32_POLY,
  parameter logic [CRC_W-1:0] INIT      = '1,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int               IN_W      = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE   = CRC_W'(CRC32_RESIDUE)
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             busy,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid,
  output logic             crc_match
);

  crc_state_e       state;
  logic [CRC_W-1:0] rmder;
  logic [CRC_W-1:0] seed;
  logic [CRC_W-1:0] step_out;

  // Only a packet in progress continues from the stored remainder; any other
  // beat (including one colliding with clear) starts a fresh packet.
  assign seed = (state == RUN && !clear) ? rmder : INIT;

  crc_lfsr_step #(
    .CRC_W    (CRC_W),
    .IN_W     (IN_W),
    .POLY     (POLY),
    .MSB_FIRST(MSB_FIRST)
  ) u_step (
    .rmder     (seed),
    .bits      (in_data),
    .next_rmder(step_out)
  );

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rmder     <= INIT;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      crc_match <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (in_valid) begin
        rmder <= step_out;
        state <= in_last ? DONE : RUN;
        if (in_last) begin
          crc_valid <= 1'b1;
          crc_out   <= step_out ^ XOR_OUT;
          crc_match <= (step_out == RESIDUE);
        end
      end else if (state != RUN || clear) begin
        rmder <= INIT;
        state <= IDLE;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: byte-wide and bit-serial instances
// checked against hand-computed CRC-32/MPEG-2 values.
module tb_crc_stream_engine;

  localparam logic [31:0] CHECK = 32'h0376E6E7;

  logic        inclk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clear = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0]  in_data = '0;
  logic        busy, crc_valid, crc_match;
  logic [31:0] crc_out;

  logic        s_clear = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [0:0]  s_data = '0;
  logic        s_busy, s_crc_valid, s_crc_match;
  logic [31:0] s_crc_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always #5 inclk = ~inclk;

  crc_stream_engine #(.IN_W(8)) dut (
    .inclk(inclk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .busy(busy), .crc_out(crc_out),
    .crc_valid(crc_valid), .crc_match(crc_match)
  );

  crc_stream_engine #(.IN_W(1), .MSB_FIRST(1'b1)) dut_s (
    .inclk(inclk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_valid),
    .in_data(s_data), .in_last(s_last), .busy(s_busy), .crc_out(s_crc_out),
    .crc_valid(s_crc_valid), .crc_match(s_crc_match)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Presents one byte beat; returns #1 after the edge that accepts it.
  task automatic beat8(input logic [7:0] d, input logic l, input logic c);
    in_valid = 1'b1; in_data = d; in_last = l; clear = c;
    @(posedge inclk); #1;
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge inclk); #1; end
  endtask

  task automatic send_msg(input logic first_clear);
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 8, first_clear && i == 0);
  endtask

  initial begin
    #1;
    check("reset_crc_out", crc_out, 32'h0);
    check("reset_valid", 32'(crc_valid), 32'h0);
    check("reset_match", 32'(crc_match), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // check value, byte-wide
    send_msg(1'b0);
    check("t1_valid", 32'(crc_valid), 32'h1);
    check("t1_crc", crc_out, CHECK);
    check("t1_busy", 32'(busy), 32'h0);
    idle(1);
    check("t1_valid_pulse", 32'(crc_valid), 32'h0);
    check("t1_crc_hold", crc_out, CHECK);

    // bit-serial with random gaps
    for (int i = 0; i < 9; i++) begin
      for (int b = 7; b >= 0; b--) begin
        s_valid = 1'b1; s_data[0] = msg[i][b]; s_last = (i == 8 && b == 0);
        @(posedge inclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        if (i == 0 && b == 7) check("t2_busy_run", 32'(s_busy), 32'h1);
        if (!(i == 8 && b == 0)) idle($urandom_range(0, 2));
      end
    end
    check("t2_valid", 32'(s_crc_valid), 32'h1);
    check("t2_crc", s_crc_out, CHECK);
    check("t2_busy_drop", 32'(s_busy), 32'h0);

    // residue check
    for (int i = 0; i < 9; i++) beat8(msg[i], 1'b0, 1'b0);
    beat8(8'h03, 1'b0, 1'b0); beat8(8'h76, 1'b0, 1'b0);
    beat8(8'hE6, 1'b0, 1'b0); beat8(8'hE7, 1'b1, 1'b0);
    check("t3_valid", 32'(crc_valid), 32'h1);
    check("t3_match", 32'(crc_match), 32'h1);
    check("t3_crc_zero", crc_out, 32'h0);
    idle(1);
    for (int i = 0; i < 9; i++) beat8((i == 4) ? 8'h34 : msg[i], 1'b0, 1'b0);
    beat8(8'h03, 1'b0, 1'b0); beat8(8'h76, 1'b0, 1'b0);
    beat8(8'hE6, 1'b0, 1'b0); beat8(8'hE7, 1'b1, 1'b0);
    check("t3_flip_valid", 32'(crc_valid), 32'h1);
    check("t3_flip_match", 32'(crc_match), 32'h0);
    idle(1);

    // back-to-back packets, then clear colliding with a first beat mid-packet
    send_msg(1'b0);
    check("t4_a_valid", 32'(crc_valid), 32'h1);
    check("t4_a_crc", crc_out, CHECK);
    beat8(msg[0], 1'b0, 1'b0);
    check("t4_b_gap_valid", 32'(crc_valid), 32'h0);
    for (int i = 1; i < 9; i++) beat8(msg[i], i == 8, 1'b0);
    check("t4_b_valid", 32'(crc_valid), 32'h1);
    check("t4_b_crc", crc_out, CHECK);
    idle(1);
    beat8(8'hAA, 1'b0, 1'b0); beat8(8'h55, 1'b0, 1'b0);
    send_msg(1'b1);
    check("t4_c_valid", 32'(crc_valid), 32'h1);
    check("t4_c_crc", crc_out, CHECK);
    idle(1);

    // reset mid-packet
    for (int i = 0; i < 4; i++) beat8(msg[i], 1'b0, 1'b0);
    check("t5_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_crc", crc_out, 32'h0);
    check("t5_rst_match", 32'(crc_match), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    @(posedge inclk); #1;
    rst_n = 1'b1;
    check("t5_rst_valid", 32'(crc_valid), 32'h0);
    send_msg(1'b0);
    check("t5_valid", 32'(crc_valid), 32'h1);
    check("t5_crc", crc_out, CHECK);
    idle(1);

    // clear alone mid-packet, then single-beat packet
    beat8(8'hAA, 1'b0, 1'b0); beat8(8'h55, 1'b0, 1'b0);
    clear = 1'b1; @(posedge inclk); #1; clear = 1'b0;
    check("t6_clear_busy", 32'(busy), 32'h0);
    send_msg(1'b0);
    check("t6_valid", 32'(crc_valid), 32'h1);
    check("t6_crc", crc_out, CHECK);
    idle(1);
    beat8(8'h31, 1'b1, 1'b0);
    check("t6_single_valid", 32'(crc_valid), 32'h1);
    check("t6_single_busy", 32'(busy), 32'h0);
    idle(1);
    check("t6_single_pulse", 32'(crc_valid), 32'h0);
    check("t6_single_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
